cr_ahbl_req_arb: RTL
====================

Name: cr_ahbl_req_arb

Overview:
- Two-master request arbiter that shares the single CPU-side AHB-Lite bus-interface request port between instruction fetch (ifu) and load/store (lsu).
- Tracks address-phase ownership, which must stay stable while the bus stalls, separately from data-phase ownership, which decides where completion, read data and errors are routed.
- Supports one address phase pipelined over one data phase.
- Sits between the core fetch/LSU units and the AHB-Lite interface block.

Parameters:
- STREAK_MAX, 4: consecutive lsu grants allowed while ifu is waiting before ifu is forced ahead (fair mode only).
- CNT_W, 3: width of the streak counter; must satisfy 2^CNT_W > STREAK_MAX.

Ports:
- ahbl_gated_clk  in  1  block clock
- cpurst_b  in  1  asynchronous active-low reset
- ifu_req  in  1  fetch request, held until ifu_grnt
- ifu_addr  in  32  fetch address (read only, word size)
- ifu_prot  in  4  fetch protection attributes
- ifu_grnt  out  1  address phase accepted for ifu
- ifu_cmplt  out  1  ifu data phase finished (ok or error)
- ifu_data_vld  out  1  ifu read data valid
- ifu_acc_err  out  1  ifu bus error
- lsu_req  in  1  load/store request, held until lsu_grnt
- lsu_addr  in  32  load/store address
- lsu_write  in  1  1 = store
- lsu_size  in  2  access size
- lsu_prot  in  4  protection attributes
- lsu_wdata  in  32  store data, held by the lsu until lsu_cmplt
- lsu_grnt / lsu_cmplt / lsu_data_vld / lsu_acc_err  out  1 each  lsu equivalents of the ifu outputs
- arb_rdata  out  32  read data, shared by both masters and qualified by the *_data_vld outputs
- cpu_req, cpu_addr[31:0], cpu_write, cpu_size[1:0], cpu_prot[3:0], cpu_wr_data[31:0]  out  downstream request port
- cpu_req_grnt, cpu_trans_cmplt, cpu_data_vld, cpu_acc_err  in  1 each  downstream response
- cpu_rdata  in  32  downstream read data
- arb_busy  out  1  any phase outstanding

Behaviour:
Address-phase owner
- aowner_vld/aowner hold the address-phase owner; reset value 0/0.
- In IDLE (aowner_vld=0), selection is combinational: lsu wins over ifu, except in fair mode when streak_cnt==STREAK_MAX and ifu_req=1, in which case ifu wins.
- cpu_req = selected requester's req. cpu_addr, cpu_write, cpu_size and cpu_prot are muxed from the selected requester.
- ifu forces cpu_write=0 and cpu_size=2'b10.
- If cpu_req=1 and cpu_req_grnt=0: set aowner_vld and lock aowner. In the following cycles only the locked master is selected, even if the other master raises req; the lock holds until grant.
- If the locked master drops req (WFG abort), clear aowner_vld.

Grant and data-phase owner
- x_grnt = cpu_req_grnt & cpu_req & (selected==x). One grant at most per cycle.
- On grant: downer_vld<=1, downer<=granted master, aowner_vld<=0. A back-to-back grant overwrites downer in the same cycle that the previous phase completes.
- Reset values: downer_vld=0, downer=0.

Response routing
- cpu_trans_cmplt, cpu_data_vld and cpu_acc_err route only to downer. The other master sees 0.
- arb_rdata = cpu_rdata, passed through.
- On cpu_trans_cmplt with no simultaneous grant: downer_vld<=0.
- An error response completes the phase. The next grant cannot occur until the downstream returns to IDLE, so no special handling is needed here.

Write data
- cpu_wr_data = lsu_wdata whenever downer=lsu; otherwise 0.

Fair mode streak counter
- streak_cnt increments on an lsu grant while ifu_req=1, saturating at STREAK_MAX.
- It clears on an ifu grant, or on any cycle with ifu_req=0.

Other
- arb_busy = aowner_vld | downer_vld. Reset value 0.
- All outputs are 0 while cpurst_b=0.
- Reset asserted mid-transfer clears all state. No response is delivered afterwards.
- Latency: zero-cycle combinational pass-through of the request; grant arrives in the same cycle as cpu_req_grnt.

Optional Feature:
- Macro CR_AHBL_ARB_FAIR_EN.
- Defined: the streak counter and ifu anti-starvation override are present.
- Undefined: strict lsu>ifu priority; streak_cnt logic is removed and STREAK_MAX is unused.

Decomposition:
- Shared package cr_ahbl_arb_pkg holds:
  - master encoding MST_IFU=1'b0, MST_LSU=1'b1;
  - IFU_SIZE=2'b10;
  - default STREAK_MAX.
- One natural sub-module, cr_ahbl_arb_sel: the combinational priority/lock/fair selector producing the selected master.
- Owner registers and the response demux stay in the top module.

Test Plan:
1. Single ifu read: ifu_req, addr 0x100, grnt immediate, cmplt+data_vld next cycle with rdata 0xDEADBEEF -> ifu_grnt cycle 0, ifu_data_vld cycle 1, all lsu outputs 0.
2. Simultaneous ifu_req+lsu_req, both granted immediately -> lsu granted first, ifu granted the next cycle. Back-to-back: downer switches lsu->ifu while the lsu cmplt is routed correctly.
3. Stall lock: ifu_req alone with cpu_req_grnt=0 for 3 cycles, lsu_req rises in cycle 1 -> cpu_addr stays ifu_addr and ifu is granted in cycle 3; lsu is granted afterwards.
4. Store data: lsu_write=1, wdata 0x12345678 granted, data phase stalls 2 cycles -> cpu_wr_data=0x12345678 throughout; lsu_data_vld never asserts; lsu_cmplt in the final cycle.
5. Error: lsu read returns cpu_acc_err+cpu_trans_cmplt -> lsu_acc_err=1, lsu_cmplt=1, ifu_acc_err=0; arb_busy drops the next cycle.
6. Fair mode: ifu_req held, lsu_req continuous, STREAK_MAX=4 -> lsu granted 4 times, then ifu, then lsu. Without the macro, ifu is never granted while lsu_req=1.

Source files
------------

// File: rtl/cr_ahbl_arb_pkg.sv
// cr_ahbl_arb_pkg: shared types and constants for the CPU-side AHB-Lite
// request arbiter (cr_ahbl_req_arb) and its selector (cr_ahbl_arb_sel).
//   mst_e          : master encoding (ifu / lsu)
//   IFU_SIZE       : fixed transfer size used for instruction fetches (word)
//   STREAK_MAX_DEF : default lsu grant streak allowed before ifu is forced
//                    ahead (fair mode, macro CR_AHBL_ARB_FAIR_EN)
package cr_ahbl_arb_pkg;

  typedef enum logic {
    MST_IFU = 1'b0,
    MST_LSU = 1'b1
  } mst_e;

  localparam logic [1:0]  IFU_SIZE       = 2'b10;
  localparam int unsigned STREAK_MAX_DEF = 4;

endpackage

// File: rtl/cr_ahbl_arb_sel.sv
// cr_ahbl_arb_sel: combinational master selector for cr_ahbl_req_arb.
// Ports:
//   ifu_req, lsu_req : requests from fetch and load/store units
//   aowner_vld       : an address phase is locked waiting for grant
//   aowner           : master owning the locked address phase
//   ifu_force        : anti-starvation override (tie low when unused)
//   sel              : selected master
//   sel_req          : request of the selected master (drives cpu_req)
module cr_ahbl_arb_sel
  import cr_ahbl_arb_pkg::*;
(
  input  logic ifu_req,
  input  logic lsu_req,
  input  logic aowner_vld,
  input  mst_e aowner,
  input  logic ifu_force,
  output mst_e sel,
  output logic sel_req
);

  always_comb begin
    sel = MST_IFU;
    if (aowner_vld) begin
      // A stalled address phase must stay stable until granted or aborted.
      sel = aowner;
    end else if (lsu_req && !(ifu_force && ifu_req)) begin
      sel = MST_LSU;
    end
    sel_req = (sel == MST_LSU) ? lsu_req : ifu_req;
  end

endmodule

// File: rtl/cr_ahbl_req_arb.sv
// cr_ahbl_req_arb: two-master (ifu, lsu) arbiter in front of the single
// CPU-side AHB-Lite request port. Tracks address-phase ownership (locked
// while the bus stalls) separately from data-phase ownership (routes
// completion, read-data-valid and error). One address phase may overlap
// one data phase.
// Optional feature: define CR_AHBL_ARB_FAIR_EN to add the lsu streak
// counter that forces ifu ahead after STREAK_MAX consecutive lsu grants
// while ifu waits. Without it, lsu has strict priority.
// Ports:
//   ahbl_gated_clk, cpurst_b        : clock, async active-low reset
//   ifu_* inputs / lsu_* inputs     : master requests and attributes
//   ifu_/lsu_ grnt,cmplt,data_vld,acc_err : per-master responses
//   arb_rdata                       : shared read data
//   cpu_* outputs                   : downstream request port
//   cpu_req_grnt, cpu_trans_cmplt, cpu_data_vld, cpu_acc_err, cpu_rdata
//                                   : downstream response
//   arb_busy                        : any phase outstanding
module cr_ahbl_req_arb
  import cr_ahbl_arb_pkg::*;
#(
  parameter int unsigned STREAK_MAX = STREAK_MAX_DEF,
  parameter int unsigned CNT_W      = 3
) (
  input  logic        ahbl_gated_clk,
  input  logic        cpurst_b,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  input  logic [3:0]  ifu_prot,
  output logic        ifu_grnt,
  output logic        ifu_cmplt,
  output logic        ifu_data_vld,
  output logic        ifu_acc_err,
  input  logic        lsu_req,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_write,
  input  logic [1:0]  lsu_size,
  input  logic [3:0]  lsu_prot,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_grnt,
  output logic        lsu_cmplt,
  output logic        lsu_data_vld,
  output logic        lsu_acc_err,
  output logic [31:0] arb_rdata,
  output logic        cpu_req,
  output logic [31:0] cpu_addr,
  output logic        cpu_write,
  output logic [1:0]  cpu_size,
  output logic [3:0]  cpu_prot,
  output logic [31:0] cpu_wr_data,
  input  logic        cpu_req_grnt,
  input  logic        cpu_trans_cmplt,
  input  logic        cpu_data_vld,
  input  logic        cpu_acc_err,
  input  logic [31:0] cpu_rdata,
  output logic        arb_busy
);

  if (CNT_W < 1 || (2 ** CNT_W) <= STREAK_MAX) begin : g_bad_cfg
    $error("cr_ahbl_req_arb: CNT_W too narrow for STREAK_MAX");
  end

  logic aowner_vld;
  mst_e aowner;
  logic downer_vld;
  mst_e downer;
  mst_e sel;
  logic sel_req;
  logic ifu_force;
  logic grnt_any;
  logic ifu_dph;
  logic lsu_dph;

  cr_ahbl_arb_sel u_sel (
    .ifu_req    (ifu_req),
    .lsu_req    (lsu_req),
    .aowner_vld (aowner_vld),
    .aowner     (aowner),
    .ifu_force  (ifu_force),
    .sel        (sel),
    .sel_req    (sel_req)
  );

  assign grnt_any = cpu_req_grnt & sel_req & cpurst_b;
  assign ifu_grnt = grnt_any & (sel == MST_IFU);
  assign lsu_grnt = grnt_any & (sel == MST_LSU);

`ifdef CR_AHBL_ARB_FAIR_EN
  localparam logic [CNT_W-1:0] STREAK_LIM = CNT_W'(STREAK_MAX);

  logic [CNT_W-1:0] streak_cnt;

  assign ifu_force = (streak_cnt == STREAK_LIM);

  always_ff @(posedge ahbl_gated_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      streak_cnt <= '0;
    end else if (!ifu_req || ifu_grnt) begin
      streak_cnt <= '0;
    end else if (lsu_grnt && (streak_cnt != STREAK_LIM)) begin
      streak_cnt <= streak_cnt + 1'b1;
    end
  end
`else
  assign ifu_force = 1'b0;
`endif

  // Address-phase lock: set on an ungranted request, cleared on grant or
  // when the locked master withdraws its request (sel_req drops).
  always_ff @(posedge ahbl_gated_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      aowner_vld <= 1'b0;
      aowner     <= MST_IFU;
    end else begin
      aowner_vld <= sel_req & ~cpu_req_grnt;
      if (sel_req) begin
        aowner <= sel;
      end
    end
  end

  // Data-phase owner: a grant in the completing cycle simply overwrites.
  always_ff @(posedge ahbl_gated_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      downer_vld <= 1'b0;
      downer     <= MST_IFU;
    end else if (grnt_any) begin
      downer_vld <= 1'b1;
      downer     <= sel;
    end else if (cpu_trans_cmplt) begin
      downer_vld <= 1'b0;
    end
  end

  always_comb begin
    cpu_req  = sel_req & cpurst_b;
    cpu_addr = '0;
    cpu_write = 1'b0;
    cpu_size = '0;
    cpu_prot = '0;
    if (cpurst_b) begin
      if (sel == MST_LSU) begin
        cpu_addr  = lsu_addr;
        cpu_write = lsu_write;
        cpu_size  = lsu_size;
        cpu_prot  = lsu_prot;
      end else begin
        cpu_addr  = ifu_addr;
        cpu_write = 1'b0;
        cpu_size  = IFU_SIZE;
        cpu_prot  = ifu_prot;
      end
    end
  end

  assign cpu_wr_data = (downer == MST_LSU) ? lsu_wdata : '0;

  assign ifu_dph = downer_vld & (downer == MST_IFU);
  assign lsu_dph = downer_vld & (downer == MST_LSU);

  assign ifu_cmplt    = cpu_trans_cmplt & ifu_dph;
  assign ifu_data_vld = cpu_data_vld    & ifu_dph;
  assign ifu_acc_err  = cpu_acc_err     & ifu_dph;
  assign lsu_cmplt    = cpu_trans_cmplt & lsu_dph;
  assign lsu_data_vld = cpu_data_vld    & lsu_dph;
  assign lsu_acc_err  = cpu_acc_err     & lsu_dph;

  assign arb_rdata = cpurst_b ? cpu_rdata : '0;
  assign arb_busy  = aowner_vld | downer_vld;

endmodule
